// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arithmetic, bit-serial shifts, optional shift-add multiply.
// Define ALU_MUL_EN to build the MUL state and datapath; otherwise code 1000 behaves as undefined.
module alu_multicycle #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned SHW = $clog2(DATA_WIDTH);
  localparam int unsigned CW  = SHW + 1;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_SLL = 4'h5,
    OP_SRL = 4'h6,
    OP_SRA = 4'h7,
    OP_MUL = 4'h8,
    OP_SLT = 4'h9
  } op_e;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
`endif

  state_e                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] res_d;
  logic                  done_d;
  logic [DATA_WIDTH-1:0] shifted;
`ifdef ALU_MUL_EN
  logic [DATA_WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] acc_sum;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    res_d   = result_o;
    done_d  = 1'b0;
`ifdef ALU_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    case (op_q)
      OP_SLL:  shifted = work_q << 1;
      OP_SRL:  shifted = work_q >> 1;
      default: shifted = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
    endcase

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          op_d    = alu_operation_i;
          work_d  = a_i;
          state_d = S_DONE;
          done_d  = 1'b1;
          case (alu_operation_i)
            OP_ADD: res_d = a_i + b_i;
            OP_SUB: res_d = a_i - b_i;
            OP_AND: res_d = a_i & b_i;
            OP_OR:  res_d = a_i | b_i;
            OP_XOR: res_d = a_i ^ b_i;
            OP_SLT: begin
              res_d    = '0;
              res_d[0] = ($signed(a_i) < $signed(b_i));
            end
            OP_SLL, OP_SRL, OP_SRA: begin
              cnt_d = CW'(b_i[SHW-1:0]);
              // A zero amount completes immediately with the unshifted operand
              if (b_i[SHW-1:0] == '0) begin
                res_d = a_i;
              end else begin
                state_d = S_SHIFT;
                done_d  = 1'b0;
              end
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
              acc_d    = '0;
              mcand_d  = a_i;
              mplier_d = b_i;
              cnt_d    = CW'(DATA_WIDTH);
              state_d  = S_MUL;
              done_d   = 1'b0;
            end
`endif
            default: res_d = '0;
          endcase
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = shifted;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = acc_sum;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      result_o <= '0;
      zero_o   <= 1'b1;
      done_o   <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_o <= res_d;
      zero_o   <= (res_d == '0);
      done_o   <= done_d;
`ifdef ALU_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

`ifdef ALU_MUL_EN
  assign busy_o = (state_q == S_SHIFT) || (state_q == S_MUL);
`else
  assign busy_o = (state_q == S_SHIFT);
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: per-cycle compare against a behavioural model
// plus directed vectors with hand-computed results and latencies.
module tb_alu_multicycle;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_i;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] result_o;
  logic         zero_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .alu_operation_i(op),
    .a_i(a), .b_i(b), .result_o(result_o), .zero_o(zero_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: result and latency straight from the op definitions
  function automatic logic [W-1:0] model_result(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int s;
    s = int'(y[4:0]);
    case (o)
      4'h0: return x + y;
      4'h1: return x - y;
      4'h2: return x & y;
      4'h3: return x | y;
      4'h4: return x ^ y;
      4'h5: return x << s;
      4'h6: return x >> s;
      4'h7: return W'($signed(x) >>> s);
`ifdef ALU_MUL_EN
      4'h8: return x * y;
`endif
      4'h9: return ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  function automatic int model_latency(input logic [3:0] o, input logic [W-1:0] y);
    case (o)
      4'h5, 4'h6, 4'h7: return int'(y[4:0]);
`ifdef ALU_MUL_EN
      4'h8: return W;
`endif
      default: return 0;
    endcase
  endfunction

  int           m_rem  = 0;
  logic [W-1:0] m_pend = '0;
  logic [W-1:0] m_res  = '0;
  logic         m_zero = 1'b1;
  logic         m_done = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rem  <= 0;
      m_res  <= '0;
      m_zero <= 1'b1;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_res  <= m_pend;
          m_zero <= (m_pend == '0);
          m_done <= 1'b1;
        end
      end else if (start_i) begin
        if (model_latency(op, b) == 0) begin
          m_res  <= model_result(op, a, b);
          m_zero <= (model_result(op, a, b) == '0);
          m_done <= 1'b1;
        end else begin
          m_rem  <= model_latency(op, b);
          m_pend <= model_result(op, a, b);
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cmp done_o", W'(done_o), W'(m_done));
    check("cmp busy_o", W'(busy_o), W'(m_rem > 0));
    check("cmp result_o", result_o, m_res);
    check("cmp zero_o", W'(zero_o), W'(m_zero));
  end

  task automatic run_op(input string name, input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp, input int exp_lat);
    int cyc;
    int bc;
    cyc = 1;
    bc  = 0;
    @(negedge clk);
    start_i = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start_i = 1'b0;
    a = ~x; b = ~y;
    while (!done_o && cyc < 200) begin
      if (busy_o) bc++;
      @(negedge clk);
      cyc++;
    end
    if (busy_o) bc++;
    check({name, " result"}, result_o, exp);
    check({name, " zero"}, W'(zero_o), W'(exp == '0));
    check({name, " latency"}, W'(cyc), W'(exp_lat + 1));
    check({name, " busy cycles"}, W'(bc), W'(exp_lat));
  endtask

  initial begin
    int cyc;
    start_i = 1'b0; op = '0; a = '0; b = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset result", result_o, '0);
    check("reset zero", W'(zero_o), W'(1));
    check("reset busy", W'(busy_o), W'(0));
    check("reset done", W'(done_o), W'(0));
    reset = 1'b0;

    // Back-to-back ADD then SUB issued in the DONE cycle
    @(negedge clk);
    start_i = 1'b1; op = 4'h0; a = 32'd5; b = 32'd7;
    @(negedge clk);
    check("b2b add done", W'(done_o), W'(1));
    check("b2b add result", result_o, 32'd12);
    check("b2b add zero", W'(zero_o), W'(0));
    op = 4'h1; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    check("b2b sub done", W'(done_o), W'(1));
    check("b2b sub result", result_o, 32'd0);
    check("b2b sub zero", W'(zero_o), W'(1));

    run_op("sll 1<<31", 4'h5, 32'd1, 32'd31, 32'h8000_0000, 31);
    run_op("sra 4", 4'h7, 32'h8000_0000, 32'd4, 32'hF800_0000, 4);
    run_op("srl by 0", 4'h6, 32'h0000_1234, 32'h20, 32'h0000_1234, 0);
    run_op("sll 4", 4'h5, 32'h0F00_000F, 32'd4, 32'hF000_00F0, 4);
    run_op("srl 8", 4'h6, 32'hF000_0000, 32'd8, 32'h00F0_0000, 8);
    run_op("and", 4'h2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0);
    run_op("or", 4'h3, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 0);
    run_op("xor", 4'h4, 32'h0000_00A5, 32'h0000_00FF, 32'h0000_005A, 0);
    run_op("sub wrap", 4'h1, 32'd0, 32'd1, 32'hFFFF_FFFF, 0);
    run_op("add wrap", 4'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
    run_op("slt neg", 4'h9, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
    run_op("slt pos", 4'h9, 32'd1, 32'hFFFF_FFFF, 32'd0, 0);
    run_op("undefined", 4'hF, 32'd9, 32'd9, 32'd0, 0);
`ifdef ALU_MUL_EN
    run_op("mul 6x7", 4'h8, 32'd6, 32'd7, 32'd42, 32);
    run_op("mul ffff x2", 4'h8, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32);
`else
    run_op("mul 6x7 off", 4'h8, 32'd6, 32'd7, 32'd0, 0);
    run_op("mul ffff x2 off", 4'h8, 32'hFFFF_FFFF, 32'd2, 32'd0, 0);
`endif

    // start_i held high with a different op during a 20-cycle SLL
    @(negedge clk);
    start_i = 1'b1; op = 4'h5; a = 32'd3; b = 32'd20;
    @(negedge clk);
    op = 4'h0; a = 32'd10; b = 32'd20;
    cyc = 1;
    while (!done_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("held sll result", result_o, 32'h0030_0000);
    check("held sll latency", W'(cyc), W'(21));
    @(negedge clk);
    start_i = 1'b0;
    check("held add done", W'(done_o), W'(1));
    check("held add result", result_o, 32'd30);

    // Asynchronous reset in the middle of a multi-cycle op
    @(negedge clk);
    start_i = 1'b1;
`ifdef ALU_MUL_EN
    op = 4'h8; a = 32'd6; b = 32'd7;
`else
    op = 4'h5; a = 32'd1; b = 32'd31;
`endif
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid reset result", result_o, '0);
    check("mid reset zero", W'(zero_o), W'(1));
    check("mid reset busy", W'(busy_o), W'(0));
    check("mid reset done", W'(done_o), W'(0));
    @(negedge clk);
    reset = 1'b0;
    run_op("add after reset", 4'h0, 32'd1, 32'd1, 32'd2, 0);
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Multi-cycle execution unit that consumes the 4-bit operation code from `ALU_Control` together with the two register/immediate operands. It returns a registered result with a start/done handshake. Simple logic and arithmetic complete in one cycle. Shifts iterate one bit per cycle, and multiply (optional) iterates shift-add. It sits directly downstream of `ALU_Control` in the execute stage and replaces the purely combinational ALU when multi-cycle ops are required.

## Interface
Parameters:
- DATA_WIDTH, 32: operand/result width; power of two, ≥ 8.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start_i  in  1  request; sampled only when state is IDLE or DONE.
- alu_operation_i  in  4  op code: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 MUL, 1001 SLT (signed); others undefined.
- a_i  in  DATA_WIDTH  operand A.
- b_i  in  DATA_WIDTH  operand B; for shifts only b_i[log2(DATA_WIDTH)-1:0] is the amount.
- result_o  out  DATA_WIDTH  registered result, held until next completion.
- zero_o  out  1  registered (result_o == 0).
- busy_o  out  1  high in SHIFT or MUL state.
- done_o  out  1  one-cycle pulse when result_o updates.

## Operation
- States: IDLE, SHIFT, MUL, DONE.
- IDLE/DONE + start_i: latch op, a_i, b_i.
  - ADD/SUB/AND/OR/XOR/SLT/undefined: compute at the same edge, go to DONE. Undefined code gives result 0.
  - Shifts: load the shift amount into a down-counter. If the amount is 0, write a_i and go to DONE. Otherwise go to SHIFT.
  - MUL: clear the accumulator, load counter = DATA_WIDTH, go to MUL.
- IDLE/DONE without start_i: DONE → IDLE; IDLE stays.
- SHIFT: shift the working register 1 bit per cycle (SLL zero-fill, SRL zero-fill, SRA sign-fill) and decrement the counter. When the counter reaches 1, write result and go to DONE.
- MUL: if multiplier LSB = 1, accumulator += multiplicand. Then shift the multiplicand left and the multiplier right. After DATA_WIDTH iterations, write the low DATA_WIDTH bits to result and go to DONE.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_WIDTH with no overflow flag. MUL result is the unsigned low half, which equals the signed low half. SLT gives 1 or 0, zero-extended.
- start_i while busy_o = 1 is ignored: no queueing and no effect on the in-flight op.
- start_i in DONE is accepted: a back-to-back op issues with no idle bubble.
- Operands are latched at acceptance, so changes on a_i/b_i afterwards have no effect.

## Timing
- Reset (async, any state, including mid-SHIFT/MUL): state IDLE, result_o = 0, zero_o = 1, busy_o = 0, done_o = 0. The in-flight op is discarded with no done pulse.
- Latency is counted from the edge that samples start_i (edge N) to the edge that raises done_o and updates result_o/zero_o:
  - single-cycle ops: done_o high after edge N;
  - shifts by s: after edge N+s (s = 0 gives edge N);
  - MUL: after edge N+DATA_WIDTH.
- done_o is high exactly one cycle per accepted op.
- busy_o rises after edge N for multi-cycle ops and falls at the same edge done_o rises.
- result_o, zero_o and done_o are all registered, with no combinational path from inputs to outputs.

## Configuration
- ALU_MUL_EN defined: MUL state and shift-add datapath are built; code 1000 behaves as above.
- ALU_MUL_EN undefined: no MUL state or accumulator. Code 1000 is treated as undefined: result 0, zero_o = 1, one-cycle latency, busy_o never asserted.

## Test plan
- Reset mid-MUL (assert at cycle 10 of 32) → outputs immediately 0/1/0/0. Next ADD 1+1 → result 2, no stray done pulse.
- ADD 5+7, then back-to-back SUB 3−3 issued in the DONE cycle → done pulses after consecutive edges; results 12 (zero_o 0), then 0 (zero_o 1).
- SLL a=1, b=31 → result 0x80000000 after 31 cycles with busy_o high throughout. SRA a=0x80000000, b=4 → 0xF8000000 after 4 cycles.
- Shift amount 0 (SRL a=0x1234, b=0x20, low 5 bits = 0) → result 0x1234 after 1 cycle, busy_o never high.
- MUL 6×7 with ALU_MUL_EN → 42 after 32 cycles. MUL 0xFFFFFFFF×2 → 0xFFFFFFFE. Without the macro → result 0 after 1 cycle.
- start_i held high with a different op during a 20-cycle SLL → ignored; the SLL result is correct and exactly one done pulse occurs before the new op is accepted in DONE.
